// File: rtl/sad_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sad_search_ctrl
// Description : Full-search motion-estimation scheduler. Walks every
//               candidate displacement of a +/-SEARCH_R window in raster
//               order (y outer, x inner), starts the SAD engine for each
//               candidate, waits for its result and keeps the minimum SAD
//               together with its motion vector.
// Options     : SAD_EARLY_EXIT_EN - when defined, a zero SAD ends the
//               search immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_search_ctrl #(
    parameter int SEARCH_R = 4,
    parameter int MV_W     = 4,
    parameter int SAD_W    = 32,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic             i_abort,
    output logic             o_sad_start,
    input  logic             i_sad_done,
    input  logic [SAD_W-1:0] i_sad_val,
    output logic [MV_W-1:0]  o_cand_x,
    output logic [MV_W-1:0]  o_cand_y,
    output logic [IDX_W-1:0] o_cand_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic [SAD_W-1:0] o_best_sad,
    output logic [MV_W-1:0]  o_best_mvx,
    output logic [MV_W-1:0]  o_best_mvy
);

    localparam logic [MV_W-1:0] c_POS_R = MV_W'(SEARCH_R);
    localparam logic [MV_W-1:0] c_NEG_R = MV_W'(-SEARCH_R);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CMP   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [MV_W-1:0]  r_cand_x;
    logic [MV_W-1:0]  r_cand_y;
    logic [IDX_W-1:0] r_cand_idx;
    logic [SAD_W-1:0] r_cur_sad;
    logic [SAD_W-1:0] r_best_sad;
    logic [MV_W-1:0]  r_best_mvx;
    logic [MV_W-1:0]  r_best_mvy;
    logic             w_last;
    logic             w_better;
    logic             w_exit;

    assign w_last   = (r_cand_x == c_POS_R) && (r_cand_y == c_POS_R);
    assign w_better = (r_cur_sad < r_best_sad);

`ifdef SAD_EARLY_EXIT_EN
    // A zero SAD cannot be beaten, so the scan stops on it.
    assign w_exit = w_last || (r_cur_sad == '0);
`else
    assign w_exit = w_last;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs; abort overrides everything, including
    // the start/done pulses of the cycle in which it is seen.
    always_comb begin
        w_next      = r_state;
        o_sad_start = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_go) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_sad_start = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                if (i_sad_done) begin
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_next = w_exit ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (i_abort) begin
            w_next      = S_IDLE;
            o_sad_start = 1'b0;
            o_done      = 1'b0;
        end
    end

    // Candidate walker, result capture and best-so-far tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand_x   <= c_NEG_R;
            r_cand_y   <= c_NEG_R;
            r_cand_idx <= '0;
            r_cur_sad  <= '0;
            r_best_sad <= '1;
            r_best_mvx <= '0;
            r_best_mvy <= '0;
        end else if (!i_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_cand_x   <= c_NEG_R;
                        r_cand_y   <= c_NEG_R;
                        r_cand_idx <= '0;
                        r_best_sad <= '1;
                        r_best_mvx <= '0;
                        r_best_mvy <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_sad_done) begin
                        r_cur_sad <= i_sad_val;
                    end
                end
                S_CMP: begin
                    // Strict compare keeps the earliest candidate on ties.
                    if (w_better) begin
                        r_best_sad <= r_cur_sad;
                        r_best_mvx <= r_cand_x;
                        r_best_mvy <= r_cand_y;
                    end
                    if (!w_exit) begin
                        r_cand_idx <= r_cand_idx + IDX_W'(1);
                        if (r_cand_x == c_POS_R) begin
                            r_cand_x <= c_NEG_R;
                            r_cand_y <= r_cand_y + MV_W'(1);
                        end else begin
                            r_cand_x <= r_cand_x + MV_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cand_x   = r_cand_x;
    assign o_cand_y   = r_cand_y;
    assign o_cand_idx = r_cand_idx;
    assign o_best_sad = r_best_sad;
    assign o_best_mvx = r_best_mvx;
    assign o_best_mvy = r_best_mvy;

endmodule
`default_nettype wire

// File: doc/sad_search_ctrl.md
Name: sad_search_ctrl

Overview:
- Full-search motion-estimation scheduler in front of the SAD datapath.
- Steps through every candidate displacement in a ±SEARCH_R window, one 16x16 block SAD per candidate.
- For each candidate it starts the SAD engine, waits for its result, and keeps the minimum SAD and its motion vector.
- On completion it reports the best SAD and motion vector to the frame-level controller.

Parameters:
- SEARCH_R, 4: search range; candidates run from -SEARCH_R to +SEARCH_R on each axis, giving (2R+1)^2 candidates (81 at default).
- MV_W, 4: signed width of motion-vector components; must satisfy 2^(MV_W-1)-1 >= SEARCH_R.
- SAD_W, 32: SAD result width.
- IDX_W, 8: candidate index width; must satisfy 2^IDX_W >= (2R+1)^2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start a search; sampled only in IDLE.
- abort  in  1  cancel the search in progress.
- sad_start  out  1  one-cycle pulse that starts the SAD engine for the current candidate.
- sad_done  in  1  one-cycle pulse from the SAD engine; sad_val is valid in the same cycle.
- sad_val  in  SAD_W  SAD result of the current candidate.
- cand_x  out  MV_W  signed x offset of the current candidate, for the address generator.
- cand_y  out  MV_W  signed y offset of the current candidate.
- cand_idx  out  IDX_W  raster index of the current candidate.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- best_sad  out  SAD_W  minimum SAD found.
- best_mvx  out  MV_W  signed x of the best candidate.
- best_mvy  out  MV_W  signed y of the best candidate.

Behaviour:
- Reset values:
  - busy=0, done=0, sad_start=0.
  - cand_x=cand_y=-SEARCH_R, cand_idx=0.
  - best_sad=all-ones, best_mvx=best_mvy=0.
  - State = IDLE.
- States: IDLE, ISSUE, WAIT, CMP, FIN.
- IDLE:
  - go=1 loads cand=(-R,-R), cand_idx=0, best_sad=all-ones, best_mv=(0,0).
  - Next state is ISSUE.
- ISSUE:
  - sad_start=1 for exactly this cycle.
  - Next state is WAIT.
- WAIT:
  - Hold until sad_done=1.
  - In that cycle, register sad_val into an internal cur_sad.
  - Next state is CMP.
- CMP:
  - If cur_sad < best_sad (strictly less), update best_sad and best_mv to the current candidate. Ties keep the earlier candidate.
  - If this is the last candidate (x=y=+R), go to FIN.
  - Otherwise advance and go to ISSUE.
- Scan order: raster, y outer and x inner. When x reaches +R it wraps to -R and y increments. cand_idx increments by 1 per candidate.
- FIN: done=1 for one cycle, busy=1; next state is IDLE.
- cand_x, cand_y and cand_idx are held stable from ISSUE through CMP of each candidate.
- Per-candidate latency: 2 + N cycles, where N = WAIT cycles including the sad_done cycle.
- Total latency from go to done: sum over candidates + 2.
- best_* outputs:
  - Update only in CMP.
  - Remain valid and stable after done until the next accepted go.
- go outside IDLE: ignored.
- sad_done outside WAIT: ignored; no state or register change.
- abort:
  - In any non-IDLE state, forces IDLE on the next edge with no done pulse and no sad_start.
  - best_* keep the partial result.
  - abort takes priority over sad_done in the same cycle.
  - In IDLE, abort has priority over go.
- Comparison is unsigned, full SAD_W bits.
- All-ones initial value: a candidate returning all-ones never replaces the initial best, so (0,0) is reported in that case.
- Asynchronous rst mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: SAD_EARLY_EXIT_EN.
- Defined: in CMP, if cur_sad==0 after the update, go directly to FIN. No further candidates are issued, and cand_idx holds the index of the zero-SAD candidate.
- Undefined: all (2R+1)^2 candidates are always evaluated; a zero SAD is treated like any other value.

Test Plan:
- Minimum search (SEARCH_R=1, 9 candidates). Stimulus: go; engine answers sad_done 3 cycles after each sad_start with sad_val=100+idx, except idx 4 returns 7. Required: exactly 9 sad_start pulses; best_sad=7, best_mv=(0,0); done pulses once, 47 cycles after the go edge.
- Tie-break (R=1). Stimulus: every candidate returns 50. Required: best_sad=50, best_mv=(-1,-1); scan order is (-1,-1),(0,-1),(1,-1),(-1,0)... (x inner, y outer).
- Abort and go-while-busy (R=1). Stimulus: assert abort in the WAIT of idx 3; pulse go while busy. Required: IDLE on the next cycle, no done; best_* equal the minimum over idx 0-2; the go pulse while busy has no effect.
- Reset mid-WAIT. Stimulus: assert rst asynchronously. Required: all outputs at reset values immediately. After release, go starts a clean search from (-R,-R) with idx 0.
- Spurious sad_done and all-ones. Stimulus: pulse sad_done in IDLE and in CMP; separately, all candidates return 0xFFFFFFFF. Required: the spurious pulses are ignored; the all-ones run reports best_sad=0xFFFFFFFF, best_mv=(0,0).
- Early exit (R=1, SAD_EARLY_EXIT_EN defined). Stimulus: idx 2 returns 0. Required: done after 3 sad_start pulses; best_mv=(1,-1). With the macro undefined, the same stimulus gives 9 pulses and the same best result.
